// File: rtl/rat_pkg.sv
// Shared types, widths and the CDB match helper for the rename alias table.
// Configuration point: ARCH_REGS, PHYS_REGS, NUM_CDB and NUM_CKPT live here.
package rat_pkg;

  localparam int unsigned ARCH_REGS = 8;
  localparam int unsigned PHYS_REGS = 32;
  localparam int unsigned NUM_CDB   = 2;
  localparam int unsigned NUM_CKPT  = 4;

  localparam int unsigned AW = $clog2(ARCH_REGS);
  localparam int unsigned PW = $clog2(PHYS_REGS);
  localparam int unsigned CW = $clog2(NUM_CKPT);

  typedef logic [PW-1:0] ptag_t;
  typedef logic [AW-1:0] areg_t;
  typedef logic [CW:0]   cptr_t;

  typedef struct packed {
    ptag_t [ARCH_REGS-1:0] tag;
    logic  [ARCH_REGS-1:0] ready;
  } map_t;

  function automatic logic cdb_hit(input ptag_t tag, input logic [NUM_CDB-1:0] valid,
                                   input ptag_t [NUM_CDB-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < int'(NUM_CDB); k++) begin
      if (valid[k] && (tags[k] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/rat_ckpt_if.sv
// Rename, wakeup and checkpoint signal bundle between rename stage and alias table.
interface rat_ckpt_if;
  import rat_pkg::*;

  logic                  flush;
  ptag_t [ARCH_REGS-1:0] commit_map;
  logic                  rename_valid;
  areg_t                 src_a;
  areg_t                 src_b;
  areg_t                 dst;
  ptag_t                 dst_tag_new;
  logic                  src_a_ready;
  ptag_t                 src_a_tag;
  logic                  src_b_ready;
  ptag_t                 src_b_tag;
  ptag_t                 dst_tag_old;
  logic  [NUM_CDB-1:0]   cdb_valid;
  ptag_t [NUM_CDB-1:0]   cdb_tag;
  logic                  ckpt_take;
  logic  [CW-1:0]        ckpt_id;
  logic                  ckpt_restore;
  logic  [CW-1:0]        ckpt_restore_id;
  logic                  ckpt_release;
  logic                  ckpt_full;
  logic  [CW:0]          ckpt_count;

  modport master (
    output flush, commit_map, rename_valid, src_a, src_b, dst, dst_tag_new,
           cdb_valid, cdb_tag, ckpt_take, ckpt_restore, ckpt_restore_id, ckpt_release,
    input  src_a_ready, src_a_tag, src_b_ready, src_b_tag, dst_tag_old,
           ckpt_id, ckpt_full, ckpt_count
  );

  modport slave (
    input  flush, commit_map, rename_valid, src_a, src_b, dst, dst_tag_new,
           cdb_valid, cdb_tag, ckpt_take, ckpt_restore, ckpt_restore_id, ckpt_release,
    output src_a_ready, src_a_tag, src_b_ready, src_b_tag, dst_tag_old,
           ckpt_id, ckpt_full, ckpt_count
  );

endinterface

// File: rtl/rat_wakeup.sv
// Applies this cycle's CDB broadcasts to the ready bits of one map.
module rat_wakeup
  import rat_pkg::*;
(
  input  map_t                map_i,
  input  logic  [NUM_CDB-1:0] cdb_valid,
  input  ptag_t [NUM_CDB-1:0] cdb_tag,
  output map_t                map_o
);

  always_comb begin
    map_o = map_i;
    for (int i = 0; i < int'(ARCH_REGS); i++) begin
      if (!map_i.ready[i] && cdb_hit(map_i.tag[i], cdb_valid, cdb_tag)) map_o.ready[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rat_ckpt.sv
// Register alias table with CDB wakeup and a ring of branch checkpoints.
// Optional RAT_CDB_BYPASS_EN forwards same-cycle CDB hits onto the source ready outputs.
module rat_ckpt
  import rat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  rat_ckpt_if.slave  rif
);

  map_t  map_q, map_d, map_woken;
  map_t  slot_q [NUM_CKPT];
  map_t  slot_d [NUM_CKPT];
  map_t  slot_woken [NUM_CKPT];
  cptr_t head_q, head_d, tail_q, tail_d;
  cptr_t count_c, dist_c;
  logic  full_c, take_ok_c, rel_ok_c, restore_live_c;
  ptag_t src_a_tag_c, src_b_tag_c;

  rat_wakeup u_wake_live (
    .map_i     (map_q),
    .cdb_valid (rif.cdb_valid),
    .cdb_tag   (rif.cdb_tag),
    .map_o     (map_woken)
  );

  // Snapshots keep listening to the CDB so a restore never misses a broadcast.
  for (genvar j = 0; j < NUM_CKPT; j++) begin : g_slot
    rat_wakeup u_wake_slot (
      .map_i     (slot_q[j]),
      .cdb_valid (rif.cdb_valid),
      .cdb_tag   (rif.cdb_tag),
      .map_o     (slot_woken[j])
    );
  end

  assign count_c        = tail_q - head_q;
  assign full_c         = (count_c == cptr_t'(NUM_CKPT));
  assign take_ok_c      = rif.ckpt_take && !full_c;
  assign rel_ok_c       = rif.ckpt_release && (count_c != '0);
  assign dist_c         = cptr_t'(CW'(rif.ckpt_restore_id - head_q[CW-1:0]));
  assign restore_live_c = (dist_c < count_c);

  always_comb begin
    map_d  = map_woken;
    slot_d = slot_woken;
    head_d = head_q;
    tail_d = tail_q;
    if (rif.flush) begin
      map_d.tag   = rif.commit_map;
      map_d.ready = '1;
      head_d      = '0;
      tail_d      = '0;
    end else if (rif.ckpt_restore) begin
      // Rebuild tail from head so the wrap bit stays consistent with the live window.
      map_d  = slot_woken[rif.ckpt_restore_id];
      tail_d = head_q + dist_c + cptr_t'(1);
      if (rel_ok_c) head_d = head_q + cptr_t'(1);
    end else begin
      if (rif.rename_valid && (rif.dst != '0)) begin
        map_d.tag[rif.dst]   = rif.dst_tag_new;
        map_d.ready[rif.dst] = 1'b0;
      end
      if (take_ok_c) tail_d = tail_q + cptr_t'(1);
      if (rel_ok_c)  head_d = head_q + cptr_t'(1);
    end
    map_d.tag[0]   = '0;
    map_d.ready[0] = 1'b1;
    if (!rif.flush && !rif.ckpt_restore && take_ok_c) slot_d[tail_q[CW-1:0]] = map_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ARCH_REGS); i++) map_q.tag[i] <= PW'(i);
      map_q.ready <= '1;
      head_q      <= '0;
      tail_q      <= '0;
    end else begin
      map_q  <= map_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_q <= slot_d;
  end

  always @(posedge clk) begin
    if (!rst && !rif.flush && rif.ckpt_restore) begin
      assert (restore_live_c);
    end
  end

  assign src_a_tag_c     = map_q.tag[rif.src_a];
  assign src_b_tag_c     = map_q.tag[rif.src_b];
  assign rif.src_a_tag   = src_a_tag_c;
  assign rif.src_b_tag   = src_b_tag_c;
  assign rif.dst_tag_old = map_q.tag[rif.dst];
`ifdef RAT_CDB_BYPASS_EN
  assign rif.src_a_ready = map_q.ready[rif.src_a] | cdb_hit(src_a_tag_c, rif.cdb_valid, rif.cdb_tag);
  assign rif.src_b_ready = map_q.ready[rif.src_b] | cdb_hit(src_b_tag_c, rif.cdb_valid, rif.cdb_tag);
`else
  assign rif.src_a_ready = map_q.ready[rif.src_a];
  assign rif.src_b_ready = map_q.ready[rif.src_b];
`endif
  assign rif.ckpt_id    = tail_q[CW-1:0];
  assign rif.ckpt_full  = full_c;
  assign rif.ckpt_count = count_c;

endmodule

// File: tb/tb_rat_ckpt.sv
// Vector-table bench for rat_ckpt: rename, wakeup, checkpoint ring and flush.
module tb_rat_ckpt;
  import rat_pkg::*;

`ifdef RAT_CDB_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  typedef struct {
    logic       rv;
    areg_t      a, b, d;
    ptag_t      nt;
    logic [1:0] cv;
    ptag_t      c0, c1;
    logic       tk, rs;
    logic [1:0] rid;
    logic       rl, fl;
    ptag_t      ea_t;
    logic       ea_r;
    ptag_t      eb_t;
    logic       eb_r;
    ptag_t      eo;
    logic [2:0] ec;
    logic       ef;
    logic [1:0] ei;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  rat_ckpt_if rif ();

  rat_ckpt dut (.clk(clk), .rst(rst), .rif(rif));

  always #5 clk = ~clk;

  vec_t tv [27];
  vec_t exp_q [$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic vec_t mk(input int rv, a, b, d, nt, cv, c0, c1, tk, rs, rid, rl, fl,
                              eat, ear, ebt, ebr, eo, ec, ef, ei);
    vec_t v;
    v.rv = 1'(rv);   v.a = AW'(a);     v.b = AW'(b);     v.d = AW'(d);
    v.nt = PW'(nt);  v.cv = 2'(cv);    v.c0 = PW'(c0);   v.c1 = PW'(c1);
    v.tk = 1'(tk);   v.rs = 1'(rs);    v.rid = 2'(rid);  v.rl = 1'(rl);  v.fl = 1'(fl);
    v.ea_t = PW'(eat); v.ea_r = 1'(ear); v.eb_t = PW'(ebt); v.eb_r = 1'(ebr);
    v.eo = PW'(eo);  v.ec = 3'(ec);    v.ef = 1'(ef);    v.ei = 2'(ei);
    return v;
  endfunction

  task automatic check(input string name);
    vec_t e;
    e = exp_q.pop_front();
    n_vec++;
    if (rif.src_a_tag !== e.ea_t || rif.src_a_ready !== e.ea_r ||
        rif.src_b_tag !== e.eb_t || rif.src_b_ready !== e.eb_r ||
        rif.dst_tag_old !== e.eo || rif.ckpt_count !== e.ec ||
        rif.ckpt_full !== e.ef || rif.ckpt_id !== e.ei) begin
      n_miss++;
      $display("FAIL %s: got a=%0d/%0b b=%0d/%0b old=%0d cnt=%0d full=%0b id=%0d, want a=%0d/%0b b=%0d/%0b old=%0d cnt=%0d full=%0b id=%0d",
               name, rif.src_a_tag, rif.src_a_ready, rif.src_b_tag, rif.src_b_ready,
               rif.dst_tag_old, rif.ckpt_count, rif.ckpt_full, rif.ckpt_id,
               e.ea_t, e.ea_r, e.eb_t, e.eb_r, e.eo, e.ec, e.ef, e.ei);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    rif.rename_valid    = v.rv;
    rif.src_a           = v.a;
    rif.src_b           = v.b;
    rif.dst             = v.d;
    rif.dst_tag_new     = v.nt;
    rif.cdb_valid       = v.cv;
    rif.cdb_tag[0]      = v.c0;
    rif.cdb_tag[1]      = v.c1;
    rif.ckpt_take       = v.tk;
    rif.ckpt_restore    = v.rs;
    rif.ckpt_restore_id = v.rid;
    rif.ckpt_release    = v.rl;
    rif.flush           = v.fl;
    exp_q.push_back(v);
    #1;
    check(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //        rv a b d nt  cv c0 c1 tk rs id rl fl | a_t a_r b_t b_r old cnt full id
    tv[0]  = mk(0,3,0,0,0,  0,0,0,  0,0,0,0,0,  3,1,0,1,0,0,0,0);
    tv[1]  = mk(1,2,1,2,17, 0,0,0,  0,0,0,0,0,  2,1,1,1,2,0,0,0);
    tv[2]  = mk(0,2,2,2,0,  2,0,17, 0,0,0,0,0,  17,BYP,17,BYP,17,0,0,0);
    tv[3]  = mk(1,2,4,4,9,  1,4,0,  0,0,0,0,0,  17,1,4,1,4,0,0,0);
    tv[4]  = mk(0,4,4,4,0,  0,0,0,  0,0,0,0,0,  9,0,9,0,9,0,0,0);
    tv[5]  = mk(0,4,3,0,0,  3,9,9,  0,0,0,0,0,  9,BYP,3,1,0,0,0,0);
    tv[6]  = mk(0,4,0,5,0,  0,0,0,  1,0,0,0,0,  9,1,0,1,5,0,0,0);
    tv[7]  = mk(1,5,0,5,20, 0,0,0,  0,0,0,0,0,  5,1,0,1,5,1,0,1);
    tv[8]  = mk(0,5,0,5,0,  1,20,0, 0,0,0,0,0,  20,BYP,0,1,20,1,0,1);
    tv[9]  = mk(1,5,0,5,21, 0,0,0,  0,0,0,0,0,  20,1,0,1,20,1,0,1);
    tv[10] = mk(1,5,0,5,22, 0,0,0,  0,1,0,0,0,  21,0,0,1,21,1,0,1);
    tv[11] = mk(0,5,2,4,0,  0,0,0,  0,0,0,0,0,  5,1,17,1,9,1,0,1);
    tv[12] = mk(0,0,0,0,0,  0,0,0,  0,0,0,1,0,  0,1,0,1,0,1,0,1);
    tv[13] = mk(0,0,0,0,0,  0,0,0,  1,0,0,0,0,  0,1,0,1,0,0,0,1);
    tv[14] = mk(0,0,0,0,0,  0,0,0,  1,0,0,0,0,  0,1,0,1,0,1,0,2);
    tv[15] = mk(0,0,0,0,0,  0,0,0,  1,0,0,0,0,  0,1,0,1,0,2,0,3);
    tv[16] = mk(0,0,0,0,0,  0,0,0,  1,0,0,0,0,  0,1,0,1,0,3,0,0);
    tv[17] = mk(1,0,0,6,30, 0,0,0,  1,0,0,0,0,  0,1,0,1,6,4,1,1);
    tv[18] = mk(0,6,0,0,0,  0,0,0,  1,0,0,1,0,  30,0,0,1,0,4,1,1);
    tv[19] = mk(0,6,0,0,0,  0,0,0,  1,0,0,1,0,  30,0,0,1,0,3,0,1);
    tv[20] = mk(0,6,0,0,0,  0,0,0,  0,1,0,0,0,  30,0,0,1,0,3,0,2);
    tv[21] = mk(0,6,5,0,0,  0,0,0,  0,0,0,0,0,  6,1,5,1,0,2,0,1);
    tv[22] = mk(1,1,7,0,5,  0,0,0,  1,0,0,0,1,  1,1,7,1,0,2,0,1);
    tv[23] = mk(0,1,7,0,0,  0,0,0,  0,0,0,0,0,  9,1,15,1,0,0,0,0);
    tv[24] = mk(0,0,6,3,0,  0,0,0,  0,0,0,0,0,  0,1,14,1,11,0,0,0);
    tv[25] = mk(1,0,0,0,5,  0,0,0,  0,0,0,0,0,  0,1,0,1,0,0,0,0);
    tv[26] = mk(0,0,0,0,0,  0,0,0,  0,0,0,0,0,  0,1,0,1,0,0,0,0);

    rst = 1'b1;
    rif.flush = 1'b0; rif.rename_valid = 1'b0; rif.src_a = '0; rif.src_b = '0;
    rif.dst = '0; rif.dst_tag_new = '0; rif.cdb_valid = '0; rif.cdb_tag = '0;
    rif.ckpt_take = 1'b0; rif.ckpt_restore = 1'b0; rif.ckpt_restore_id = '0;
    rif.ckpt_release = 1'b0;
    for (int i = 0; i < int'(ARCH_REGS); i++) rif.commit_map[i] = PW'(i + 8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 27; i++) apply(tv[i], $sformatf("vec%0d", i));

    // Snapshot wakeup carried through a restore that also releases the restored slot.
    apply(mk(1,3,0,3,25, 0,0,0,  1,0,0,0,0,  11,1,0,1,11,0,0,0), "seq_take_rename");
    apply(mk(0,3,0,0,0,  1,25,0, 1,0,0,0,0,  25,BYP,0,1,0,1,0,1), "seq_take_cdb");
    apply(mk(0,3,0,0,0,  0,0,0,  0,1,0,1,0,  25,1,0,1,0,2,0,2), "seq_restore_release");
    apply(mk(0,3,0,3,0,  0,0,0,  0,0,0,0,0,  25,1,0,1,25,0,0,1), "seq_after_restore");

    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
